// File: rtl/vppm_tx.sv
// vppm_tx -- VPPM transmitter.
// Serialises NBITS-wide words into a variable-pulse-position-modulated line.
// Frame from idle: PREAMBLE_LEN '0' symbols, one '1' sync symbol, then the
// data bits MSB first. A word accepted in the last cycle of the LSB symbol
// follows immediately with sync + data and no preamble.
// Symbol waveform for symbol-relative cycle k:
//   '0' : high while k <  HIGH_CYCLES
//   '1' : high while k >= SYMBOL_CYCLES-HIGH_CYCLES
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   dataIn    : word to transmit, captured on dataValid && dataReady
//   dataValid : dataIn holds a valid word
//   dataReady : block accepts a word this cycle (registered)
//   vppmOut   : modulated line output (registered)
//   txActive  : high while a frame is on the line (registered)
module vppm_tx #(
  parameter int NBITS         = 12,
  parameter int SYMBOL_CYCLES = 40,
  parameter int HIGH_CYCLES   = 20,
  parameter int PREAMBLE_LEN  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             vppmOut,
  output logic             txActive
);

  localparam int KW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [KW-1:0] K_LAST      = KW'(SYMBOL_CYCLES - 1);
  localparam logic [KW-1:0] K_HIGH      = KW'(HIGH_CYCLES);
  localparam logic [KW-1:0] K_ONE_START = KW'(SYMBOL_CYCLES - HIGH_CYCLES);
  localparam logic [PW-1:0] P_LAST      = PW'(PREAMBLE_LEN - 1);
  localparam logic [BW-1:0] B_MSB       = BW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, DATA} state_t;

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [NBITS-1:0] shift_reg, shift_next;
  logic             ready_reg, ready_next;
  logic             vppm_reg, vppm_next;
  logic             active_reg, active_next;
  logic             transfer;
  logic             sym_end;
  logic             sym_bit;

  always_comb begin
    transfer   = dataValid && ready_reg;
    sym_end    = (k_reg == K_LAST);
    state_next = state_reg;
    k_next     = k_reg;
    pre_next   = pre_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    sym_bit    = 1'b0;

    if (state_reg != IDLE) begin
      k_next = sym_end ? '0 : k_reg + KW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (transfer) begin
          state_next = PREAMBLE;
          k_next     = '0;
          pre_next   = '0;
          shift_next = dataIn;
        end
      end
      PREAMBLE: begin
        if (sym_end) begin
          if (pre_reg == P_LAST) begin
            state_next = SYNC;
          end else begin
            pre_next = pre_reg + PW'(1);
          end
        end
      end
      SYNC: begin
        if (sym_end) begin
          state_next = DATA;
          bit_next   = B_MSB;
        end
      end
      DATA: begin
        if (sym_end) begin
          if (bit_reg == '0) begin
            // A word taken in the final LSB cycle chains straight into sync.
            if (transfer) begin
              state_next = SYNC;
              shift_next = dataIn;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next   = bit_reg - BW'(1);
            shift_next = shift_reg << 1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered
    // and still line up with the symbol the line is carrying.
    case (state_next)
      SYNC:    sym_bit = 1'b1;
      DATA:    sym_bit = shift_next[NBITS-1];
      default: sym_bit = 1'b0;
    endcase

    if (state_next == IDLE) begin
      vppm_next = 1'b0;
    end else if (sym_bit) begin
      vppm_next = (k_next >= K_ONE_START);
    end else begin
      vppm_next = (k_next < K_HIGH);
    end
    active_next = (state_next != IDLE);
    ready_next  = (state_next == IDLE) ||
                  ((state_next == DATA) && (bit_next == '0) && (k_next == K_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      pre_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      ready_reg  <= 1'b0;
      vppm_reg   <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      pre_reg    <= pre_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      ready_reg  <= ready_next;
      vppm_reg   <= vppm_next;
      active_reg <= active_next;
    end
  end

  assign dataReady = ready_reg;
  assign vppmOut   = vppm_reg;
  assign txActive  = active_reg;

endmodule

// File: tb/tb_vppm_tx.sv
// tb_vppm_tx -- bench for vppm_tx.
// Two instances share all inputs: one at the default pulse width (20) and one
// dimmed (HIGH_CYCLES=10). A symbol-queue model predicts every output of both
// instances and is compared on each falling edge; directed scenarios add
// literal expectations on recorded frame traces.
module tb_vppm_tx;

  localparam int NB = 12;
  localparam int SC = 40;
  localparam int PL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dataValid = 1'b1;
  logic [NB-1:0] dataIn = 12'h777;
  logic [1:0]    rdy;
  logic [1:0]    vppm;
  logic [1:0]    act;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vppm_tx #(.NBITS(NB), .SYMBOL_CYCLES(SC), .HIGH_CYCLES(20), .PREAMBLE_LEN(PL)) dut0 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(rdy[0]), .vppmOut(vppm[0]), .txActive(act[0])
  );

  vppm_tx #(.NBITS(NB), .SYMBOL_CYCLES(SC), .HIGH_CYCLES(10), .PREAMBLE_LEN(PL)) dut1 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(rdy[1]), .vppmOut(vppm[1]), .txActive(act[1])
  );

  // Model: a queue of symbols still to be sent plus the position in the head symbol.
  bit sym [2][64];
  int head [2];
  int cnt [2];
  int t [2];
  bit e_v [2];
  bit e_a [2];
  bit e_r [2];
  bit model_live = 1'b0;
  int xfer_count = 0;

  // Recorded traces of a frame (instance 0 for ready/active).
  bit tr_v0 [1024];
  bit tr_v1 [1024];
  bit tr_a  [1024];
  bit tr_r  [1024];
  int hi0, hi1, act_n, rdy_n;

  function automatic int hc_of(input int m);
    return (m == 0) ? 20 : 10;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int m, input bit b);
    sym[m][(head[m] + cnt[m]) % 64] = b;
    cnt[m]++;
  endtask

  // Advance the model over the rising edge that has just passed, using the
  // inputs that were applied to that edge.
  task automatic model_step();
    bit xfer;
    bit was_idle;
    bit s;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        cnt[m] = 0; head[m] = 0; t[m] = 0;
        e_v[m] = 1'b0; e_a[m] = 1'b0; e_r[m] = 1'b0;
      end else begin
        xfer = dataValid && e_r[m];
        was_idle = (cnt[m] == 0);
        if (!was_idle) begin
          t[m]++;
          if (t[m] == SC) begin
            t[m] = 0;
            head[m] = (head[m] + 1) % 64;
            cnt[m]--;
          end
        end
        if (xfer) begin
          if (m == 0) xfer_count++;
          if (was_idle) for (int i = 0; i < PL; i++) push(m, 1'b0);
          push(m, 1'b1);
          for (int b = NB - 1; b >= 0; b--) push(m, dataIn[b]);
        end
        if (cnt[m] > 0) begin
          s = sym[m][head[m]];
          e_v[m] = s ? (t[m] >= SC - hc_of(m)) : (t[m] < hc_of(m));
          e_a[m] = 1'b1;
          e_r[m] = (cnt[m] == 1) && (t[m] == SC - 1);
        end else begin
          e_v[m] = 1'b0; e_a[m] = 1'b0; e_r[m] = 1'b1;
        end
      end
    end
    if (rst) model_live = 1'b1;
  endtask

  // All time passes through here: step the model and compare both instances.
  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    if (model_live) begin
      check("cycle_dut0", {29'd0, vppm[0], act[0], rdy[0]}, {29'd0, e_v[0], e_a[0], e_r[0]});
      check("cycle_dut1", {29'd0, vppm[1], act[1], rdy[1]}, {29'd0, e_v[1], e_a[1], e_r[1]});
    end
  endtask

  task automatic wait_accept(input string name);
    int start;
    int n;
    start = xfer_count;
    n = 0;
    while (xfer_count == start && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(xfer_count != start), 32'd1);
  endtask

  task automatic record(input int n, input int stray);
    hi0 = 0; hi1 = 0; act_n = 0; rdy_n = 0;
    for (int c = 0; c < n; c++) begin
      tr_v0[c] = vppm[0]; tr_v1[c] = vppm[1]; tr_a[c] = act[0]; tr_r[c] = rdy[0];
      hi0 += int'(vppm[0]); hi1 += int'(vppm[1]);
      act_n += int'(act[0]); rdy_n += int'(rdy[0]);
      if (stray >= 0 && c == stray) begin
        dataValid = 1'b1;
        dataIn = 12'h123;
      end else if (stray >= 0 && c == stray + 1) begin
        dataValid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {29'd0, vppm[0], act[0], rdy[0]}, 32'b001);
  endtask

  initial begin
    bit hold;

    // Reset held for 3 cycles with dataValid asserted.
    repeat (3) tick();
    check("reset_outputs", {29'd0, vppm[0], act[0], rdy[0]}, 32'd0);
    rst = 1'b0;
    dataValid = 1'b0;
    tick();
    check("ready_after_reset", 32'(rdy[0]), 32'd1);
    repeat (5) tick();
    check("no_capture_in_reset", 32'(act[0]), 32'd0);

    // Single word 12'hAAA from idle.
    dataIn = 12'hAAA;
    dataValid = 1'b1;
    wait_accept("accept_aaa");
    dataValid = 1'b0;
    record(840, -1);
    check("aaa_len", 32'(act_n), 32'd840);
    check("aaa_hi0", 32'(hi0), 32'd420);
    check("aaa_hi1_dim", 32'(hi1), 32'd210);
    check("aaa_first", 32'(tr_v0[0]), 32'd1);
    check("aaa_sync_k0", 32'(tr_v0[320]), 32'd0);
    check("aaa_sync_k39", 32'(tr_v0[359]), 32'd1);
    check("aaa_d11_k0", 32'(tr_v0[360]), 32'd0);
    check("aaa_d11_k20", 32'(tr_v0[380]), 32'd1);
    check("aaa_d10_k0", 32'(tr_v0[400]), 32'd1);
    check("dim_zero_k9", 32'(tr_v1[9]), 32'd1);
    check("dim_zero_k10", 32'(tr_v1[10]), 32'd0);
    check("dim_one_k29", 32'(tr_v1[349]), 32'd0);
    check("dim_one_k30", 32'(tr_v1[350]), 32'd1);
    check_idle("aaa_end_idle");

    // Back-to-back 12'hFFF then 12'h000 with dataValid held.
    dataIn = 12'hFFF;
    dataValid = 1'b1;
    wait_accept("accept_fff");
    dataIn = 12'h000;
    record(840, -1);
    dataValid = 1'b0;
    check("b2b_ready_pulses", 32'(rdy_n), 32'd1);
    check("b2b_ready_at_839", 32'(tr_r[839]), 32'd1);
    check("b2b_fff_hi0", 32'(hi0), 32'd420);
    record(520, -1);
    check("b2b2_len", 32'(act_n), 32'd520);
    check("b2b2_sync_k0", 32'(tr_v0[0]), 32'd0);
    check("b2b2_sync_k20", 32'(tr_v0[20]), 32'd1);
    check("b2b2_d_k0", 32'(tr_v0[40]), 32'd1);
    check("b2b2_d_k20", 32'(tr_v0[60]), 32'd0);
    check_idle("b2b_end_idle");

    // Reset at frame cycle 500, then a full frame of 12'h5A5.
    dataIn = 12'h3C3;
    dataValid = 1'b1;
    wait_accept("accept_3c3");
    dataValid = 1'b0;
    record(500, -1);
    rst = 1'b1;
    tick();
    check("midrst_outputs", {29'd0, vppm[0], act[0], rdy[0]}, 32'd0);
    rst = 1'b0;
    tick();
    check_idle("midrst_idle");
    dataIn = 12'h5A5;
    dataValid = 1'b1;
    wait_accept("accept_5a5");
    dataValid = 1'b0;
    record(840, -1);
    check("5a5_len", 32'(act_n), 32'd840);
    check("5a5_pre_k0", 32'(tr_v0[0]), 32'd1);
    check("5a5_pre7_k20", 32'(tr_v0[300]), 32'd0);
    check("5a5_sync_k20", 32'(tr_v0[340]), 32'd1);
    check("5a5_d11_k0", 32'(tr_v0[360]), 32'd1);
    check("5a5_d11_k20", 32'(tr_v0[380]), 32'd0);
    check_idle("5a5_end_idle");

    // Stray dataValid pulse while busy must be ignored.
    dataIn = 12'h0F0;
    dataValid = 1'b1;
    wait_accept("accept_0f0");
    dataValid = 1'b0;
    record(840, 300);
    check("stray_len", 32'(act_n), 32'd840);
    check_idle("stray_end_idle");
    record(100, -1);
    check("stray_no_frame", 32'(act_n), 32'd0);

    // Randomised traffic, including held-valid stretches and rare resets.
    hold = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if (i % 2500 == 0) hold = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 2999) == 0);
      dataValid = hold ? 1'b1 : ($urandom_range(0, 15) == 0);
      dataIn = NB'($urandom);
      tick();
    end
    rst = 1'b0;
    dataValid = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
